// File: rtl/regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wr_arbiter
//
// Round-robin write-port arbiter in front of the register file (a bank of
// reg_no_rst registers). Up to NUM_REQ sources present level write requests;
// one is granted per cycle, and the grant drives a one-hot register enable plus
// a shared data bus into the bank. Writes to x0 are dropped (and flagged),
// writes beyond the last implemented register are silently ignored, and every
// write that lands in registers 1..NUM_REGS-1 is counted.
//
// Ports
//   CLK        clock, all state updates on posedge
//   RST_N      asynchronous active-low reset
//   STALL      high blocks new grants (a grant already issued is not cancelled)
//   REQ        per-requester write request, held until GNT is seen
//   ADDR       packed target addresses, requester i at [i*ADDR_W +: ADDR_W]
//   WDATA      packed write data, requester i at [i*REG_SIZE +: REG_SIZE]
//   GNT        registered one-hot grant, one-cycle pulse
//   REG_ENA    registered one-hot register enable into the bank
//   REG_DATA   registered write data into the bank (holds when idle)
//   ZERO_DROP  one-cycle pulse: the granted write targeted x0 and was discarded
//   WR_CNT     16-bit wrapping count of writes committed to registers 1..N-1
// -----------------------------------------------------------------------------
module regfile_wr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int REG_SIZE = 32,
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         STALL,
   input  logic [NUM_REQ-1:0]           REQ,
   input  logic [NUM_REQ*ADDR_W-1:0]    ADDR,
   input  logic [NUM_REQ*REG_SIZE-1:0]  WDATA,
   output logic [NUM_REQ-1:0]           GNT,
   output logic [NUM_REGS-1:0]          REG_ENA,
   output logic [REG_SIZE-1:0]          REG_DATA,
   output logic                         ZERO_DROP,
   output logic [15:0]                  WR_CNT
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // One extra bit so the range compare cannot overflow when NUM_REGS == 2**ADDR_W.
   localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
   localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

   // State
   logic [NUM_REQ-1:0]  gnt_reg,       gnt_next;
   logic [NUM_REGS-1:0] reg_ena_reg,   reg_ena_next;
   logic [REG_SIZE-1:0] reg_data_reg,  reg_data_next;
   logic                zero_drop_reg, zero_drop_next;
   logic [15:0]         wr_cnt_reg,    wr_cnt_next;
   logic [PTR_W-1:0]    ptr_reg,       ptr_next;

   // Unpacked views of the per-requester address/data slices
   logic [ADDR_W-1:0]   req_addr [NUM_REQ];
   logic [REG_SIZE-1:0] req_data [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign req_addr[gi] = ADDR[gi*ADDR_W +: ADDR_W];
         assign req_data[gi] = WDATA[gi*REG_SIZE +: REG_SIZE];
      end
   endgenerate

   // Winner selection: first eligible requester at or after the pointer,
   // wrapping. The source granted this cycle is masked out so that a requester
   // still holding REQ while it sees GNT cannot be granted twice in a row.
   logic [NUM_REQ-1:0] eligible;
   logic               win_valid;
   logic [PTR_W-1:0]   win_idx;

   always_comb begin
      eligible  = REQ & ~gnt_reg;
      win_valid = 1'b0;
      win_idx   = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         int idx;
         idx = int'(ptr_reg) + off;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!win_valid && eligible[idx]) begin
            win_valid = 1'b1;
            win_idx   = PTR_W'(idx);
         end
      end
   end

   logic [ADDR_W-1:0]   win_addr;
   logic [REG_SIZE-1:0] win_data;
   logic                addr_zero;
   logic                addr_in_range;

   assign win_addr      = req_addr[win_idx];
   assign win_data      = req_data[win_idx];
   assign addr_zero     = (win_addr == '0);
   assign addr_in_range = ({1'b0, win_addr} < NUM_REGS_W);

   // Address decode into the bank; x0 never gets an enable line.
   logic [NUM_REGS-1:0] ena_dec;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
         if (gi == 0) begin : g_x0
            assign ena_dec[gi] = 1'b0;
         end else begin : g_xn
            assign ena_dec[gi] = (win_addr == ADDR_W'(gi));
         end
      end
   endgenerate

   // Next-state logic
   always_comb begin
      gnt_next       = '0;
      reg_ena_next   = '0;
      zero_drop_next = 1'b0;
      reg_data_next  = reg_data_reg;
      wr_cnt_next    = wr_cnt_reg;
      ptr_next       = ptr_reg;

      if (win_valid && !STALL) begin
         gnt_next[win_idx] = 1'b1;
         reg_data_next     = win_data;
         ptr_next          = (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
         if (addr_zero) begin
            zero_drop_next = 1'b1;
         end else if (addr_in_range) begin
            reg_ena_next = ena_dec;
            wr_cnt_next  = wr_cnt_reg + 16'd1;
         end
         // Out-of-range targets: grant is issued, nothing is written or counted.
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         gnt_reg       <= '0;
         reg_ena_reg   <= '0;
         reg_data_reg  <= '0;
         zero_drop_reg <= 1'b0;
         wr_cnt_reg    <= '0;
         ptr_reg       <= '0;
      end else begin
         gnt_reg       <= gnt_next;
         reg_ena_reg   <= reg_ena_next;
         reg_data_reg  <= reg_data_next;
         zero_drop_reg <= zero_drop_next;
         wr_cnt_reg    <= wr_cnt_next;
         ptr_reg       <= ptr_next;
      end
   end

   assign GNT       = gnt_reg;
   assign REG_ENA   = reg_ena_reg;
   assign REG_DATA  = reg_data_reg;
   assign ZERO_DROP = zero_drop_reg;
   assign WR_CNT    = wr_cnt_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wr_arbiter
//
// Directed bench for regfile_wr_arbiter (NUM_REQ=4, REG_SIZE=32, NUM_REGS=32,
// ADDR_W=5). Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int REG_SIZE = 32;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;

   logic                         CLK;
   logic                         RST_N;
   logic                         STALL;
   logic [NUM_REQ-1:0]           REQ;
   logic [NUM_REQ*ADDR_W-1:0]    ADDR;
   logic [NUM_REQ*REG_SIZE-1:0]  WDATA;
   logic [NUM_REQ-1:0]           GNT;
   logic [NUM_REGS-1:0]          REG_ENA;
   logic [REG_SIZE-1:0]          REG_DATA;
   logic                         ZERO_DROP;
   logic [15:0]                  WR_CNT;

   int checks_total  = 0;
   int checks_passed = 0;
   int checks_failed = 0;

   regfile_wr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .REG_SIZE (REG_SIZE),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .STALL     (STALL),
      .REQ       (REQ),
      .ADDR      (ADDR),
      .WDATA     (WDATA),
      .GNT       (GNT),
      .REG_ENA   (REG_ENA),
      .REG_DATA  (REG_DATA),
      .ZERO_DROP (ZERO_DROP),
      .WR_CNT    (WR_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else begin
         checks_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic show(input string what);
      $display("txn %-10s GNT=%b REG_ENA=0x%08h REG_DATA=0x%08h ZERO_DROP=%0d WR_CNT=%0d",
               what, GNT, REG_ENA, REG_DATA, ZERO_DROP, WR_CNT);
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [REG_SIZE-1:0] d);
      ADDR[i*ADDR_W +: ADDR_W]     = a;
      WDATA[i*REG_SIZE +: REG_SIZE] = d;
   endtask

   logic [NUM_REQ-1:0] prev_gnt;

   initial begin
      RST_N = 1'b0;
      STALL = 1'b0;
      REQ   = '0;
      ADDR  = '0;
      WDATA = '0;

      // ---------------- reset state ----------------
      step();
      step();
      show("reset");
      check("rst_gnt",       64'(GNT),       64'h0);
      check("rst_reg_ena",   64'(REG_ENA),   64'h0);
      check("rst_reg_data",  64'(REG_DATA),  64'h0);
      check("rst_zero_drop", 64'(ZERO_DROP), 64'h0);
      check("rst_wr_cnt",    64'(WR_CNT),    64'h0);
      RST_N = 1'b1;
      step();

      // ---------------- asynchronous reset mid-grant ----------------
      set_req(0, 5'd2, 32'h0000_0055);
      REQ = 4'b0001;
      step();
      show("pre_rst");
      check("arst_pre_ena", 64'(REG_ENA), 64'h4);
      check("arst_pre_cnt", 64'(WR_CNT),  64'h1);
      REQ = '0;
      #2;
      RST_N = 1'b0;
      #1;
      show("mid_rst");
      check("arst_ena", 64'(REG_ENA), 64'h0);
      check("arst_gnt", 64'(GNT),     64'h0);
      check("arst_cnt", 64'(WR_CNT),  64'h0);
      #1;
      RST_N = 1'b1;

      // Pointer was 1 before reset; a fresh pointer picks requester 0 first.
      set_req(0, 5'd5, 32'hDEAD_BEEF);
      set_req(1, 5'd3, 32'h0000_1111);
      REQ = 4'b0011;
      step();
      show("ptr0");
      check("ptr0_gnt",  64'(GNT),      64'h1);
      check("ptr0_ena",  64'(REG_ENA),  64'h20);
      check("ptr0_data", 64'(REG_DATA), 64'hDEAD_BEEF);
      check("ptr0_cnt",  64'(WR_CNT),   64'h1);
      REQ = 4'b0010;
      step();
      show("req1");
      check("req1_gnt",  64'(GNT),      64'h2);
      check("req1_ena",  64'(REG_ENA),  64'h8);
      check("req1_data", 64'(REG_DATA), 64'h1111);
      check("req1_cnt",  64'(WR_CNT),   64'h2);
      REQ = '0;
      step();
      show("idle");
      check("idle_gnt",  64'(GNT),      64'h0);
      check("idle_ena",  64'(REG_ENA),  64'h0);
      check("idle_data", 64'(REG_DATA), 64'h1111);
      check("idle_cnt",  64'(WR_CNT),   64'h2);

      // ---------------- single write (pointer at 2, wraps to 0) ----------------
      set_req(0, 5'd5, 32'hDEAD_BEEF);
      REQ = 4'b0001;
      step();
      show("single");
      check("single_gnt",  64'(GNT),      64'h1);
      check("single_ena",  64'(REG_ENA),  64'h0000_0020);
      check("single_data", 64'(REG_DATA), 64'hDEAD_BEEF);
      check("single_cnt",  64'(WR_CNT),   64'h3);
      REQ = '0;
      step();

      // ---------------- round robin from a clean reset ----------------
      RST_N = 1'b0;
      #3;
      RST_N = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, ADDR_W'(i + 1), 32'hA0 + 32'(i));
      REQ      = 4'b1111;
      prev_gnt = '0;
      for (int k = 0; k < 8; k++) begin
         step();
         show("rr");
         check("rr_gnt",    64'(GNT),      64'(1) << (k % 4));
         check("rr_ena",    64'(REG_ENA),  64'(1) << ((k % 4) + 1));
         check("rr_data",   64'(REG_DATA), 64'hA0 + 64'(k % 4));
         check("rr_cnt",    64'(WR_CNT),   64'(k + 1));
         check("rr_no_rep", 64'(GNT & prev_gnt), 64'h0);
         prev_gnt = GNT;
      end
      REQ = '0;
      step();
      check("rr_idle_gnt", 64'(GNT), 64'h0);
      check("rr_final_cnt", 64'(WR_CNT), 64'h8);

      // ---------------- x0 write ----------------
      set_req(2, 5'd0, 32'h0000_1234);
      REQ = 4'b0100;
      step();
      show("x0");
      check("x0_gnt",  64'(GNT),       64'h4);
      check("x0_ena",  64'(REG_ENA),   64'h0);
      check("x0_drop", 64'(ZERO_DROP), 64'h1);
      check("x0_data", 64'(REG_DATA),  64'h1234);
      check("x0_cnt",  64'(WR_CNT),    64'h8);
      REQ = '0;
      step();
      check("x0_drop_pulse", 64'(ZERO_DROP), 64'h0);
      check("x0_gnt_pulse",  64'(GNT),       64'h0);

      // ---------------- stall (pointer now 3) ----------------
      set_req(0, 5'd1, 32'h10);
      set_req(1, 5'd2, 32'h20);
      REQ   = 4'b0011;
      STALL = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         show("stall");
         check("stall_gnt", 64'(GNT),     64'h0);
         check("stall_ena", 64'(REG_ENA), 64'h0);
      end
      STALL = 1'b0;
      step();
      show("unstall0");
      check("unstall_gnt0", 64'(GNT),     64'h1);
      check("unstall_ena0", 64'(REG_ENA), 64'h2);
      check("unstall_cnt0", 64'(WR_CNT),  64'h9);
      step();
      show("unstall1");
      check("unstall_gnt1", 64'(GNT),     64'h2);
      check("unstall_ena1", 64'(REG_ENA), 64'h4);
      check("unstall_cnt1", 64'(WR_CNT),  64'hA);
      // Stall raised while a grant is showing only blocks the following one.
      STALL = 1'b1;
      #1;
      check("stall_keep_gnt", 64'(GNT), 64'h2);
      step();
      show("stall_blk");
      check("stall_blk_gnt",  64'(GNT),      64'h0);
      check("stall_blk_data", 64'(REG_DATA), 64'h20);
      STALL = 1'b0;
      REQ   = '0;
      step();

      // ---------------- counter wrap ----------------
      RST_N = 1'b0;
      #3;
      RST_N = 1'b1;
      set_req(0, 5'd1, 32'h1);
      set_req(1, 5'd3, 32'h3);
      REQ = 4'b0011;
      for (int k = 0; k < 65535; k++) step();
      show("preload");
      check("wrap_pre_cnt", 64'(WR_CNT), 64'hFFFF);
      check("wrap_pre_gnt", 64'(GNT),    64'h1);
      set_req(1, 5'd7, 32'h77);
      REQ = 4'b0010;
      step();
      show("wrap");
      check("wrap_gnt",  64'(GNT),      64'h2);
      check("wrap_ena",  64'(REG_ENA),  64'h80);
      check("wrap_data", 64'(REG_DATA), 64'h77);
      check("wrap_cnt",  64'(WR_CNT),   64'h0);
      REQ = '0;
      step();
      check("wrap_idle_ena", 64'(REG_ENA), 64'h0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Round-robin write-port arbiter for the RISC-V register file, which is built from reg_no_rst banks.
- Accepts write requests from NUM_REQ sources (e.g. ALU writeback, load unit, CSR unit, debug) and grants one per cycle.
- Drives one-hot per-register enables plus a shared data bus into the register bank.
- Enforces the x0 hardwired-zero rule and counts completed writes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- REG_SIZE, 32, register data width
- NUM_REGS, 32, registers in the bank
- ADDR_W, 5, register address width (2**ADDR_W >= NUM_REGS)

Ports:
- CLK  input  1  clock; all state updates on posedge
- RST_N  input  1  asynchronous, active-low reset
- STALL  input  1  high blocks new grants
- REQ  input  NUM_REQ  per-requester write request, level
- ADDR  input  NUM_REQ*ADDR_W  packed target addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
- WDATA  input  NUM_REQ*REG_SIZE  packed write data; requester i uses slice [i*REG_SIZE +: REG_SIZE]
- GNT  output  NUM_REQ  one-hot grant, registered, one-cycle pulse
- REG_ENA  output  NUM_REGS  one-hot register enable to the bank (feeds ENA of each reg_no_rst), registered
- REG_DATA  output  REG_SIZE  write data to all registers, registered
- ZERO_DROP  output  1  pulse: the granted write targeted x0 and was discarded
- WR_CNT  output  16  count of writes committed to registers 1..NUM_REGS-1

Behaviour:
- Reset (RST_N low, asynchronous):
  - GNT=0, REG_ENA=0, REG_DATA=0, ZERO_DROP=0, WR_CNT=0.
  - Round-robin pointer PTR=0.
  - Reset mid-grant kills the pending write: REG_ENA clears immediately.
- Protocol:
  - A requester holds REQ, ADDR and WDATA stable until it sees GNT high.
  - It then either deasserts REQ or presents the next write.
- Arbitration (each posedge, when not in reset):
  - Eligible set E = REQ & ~GNT. The requester granted in the current cycle is masked, so the same source cannot be granted on consecutive cycles.
  - If STALL=1 or E=0: next GNT=0, REG_ENA=0, ZERO_DROP=0, and REG_DATA holds its value.
  - Otherwise the winner W is the first set bit of E searching from PTR upward, wrapping at NUM_REQ-1 to 0.
  - Next state: GNT=one-hot(W), REG_DATA=WDATA[W], PTR=(W+1) mod NUM_REQ.
- Commit:
  - If ADDR[W]==0: REG_ENA=0, ZERO_DROP=1, WR_CNT unchanged.
  - Else if ADDR[W]>=NUM_REGS: REG_ENA=0, ZERO_DROP=0, WR_CNT unchanged. The write is silently ignored; GNT is still issued.
  - Else: REG_ENA=one-hot(ADDR[W]), WR_CNT increments and wraps from 0xFFFF to 0.
- Latency:
  - REQ sampled at edge k. GNT/REG_ENA/REG_DATA are high during cycle k+1.
  - The register bank captures at edge k+1.
  - The written value is visible on the register R output after edge k+1 (two edges after request sample).
- Invariants:
  - At most one GNT bit and at most one REG_ENA bit high in any cycle.
  - REG_ENA is nonzero only in a cycle where GNT is nonzero.
- PTR is unchanged in any cycle with no grant.
- STALL asserted while GNT is high does not cancel that grant; it only blocks the next one.

Test Plan:
- Reset behaviour: RST_N=0 asynchronously mid-cycle while REG_ENA=0x4 -> REG_ENA, GNT and WR_CNT drop to 0 before the next edge; PTR=0 after release.
- Single write: REQ=0001, ADDR0=5, WDATA0=0xDEADBEEF -> next cycle GNT=0001, REG_ENA=0x00000020, REG_DATA=0xDEADBEEF; WR_CNT=1.
- Round-robin fairness: REQ=1111 held continuously, all ADDR=1..4 -> grant order 0,1,2,3,0,...; no GNT bit high in two consecutive cycles; WR_CNT=8 after 8 grants.
- x0 write: requester 2 writes ADDR=0, WDATA=0x1234 -> GNT=0100, REG_ENA=0, ZERO_DROP=1 for one cycle, WR_CNT unchanged.
- Stall: REQ=0011 with STALL=1 for 3 cycles -> GNT=0 and PTR frozen; STALL drops -> GNT=0001, then 0010.
- Counter wrap: preload by driving 65535 writes -> WR_CNT=0xFFFF; one more write to reg 7 -> WR_CNT=0x0000 and REG_ENA=0x80.
